// File: rtl/rv32i_types.sv
// Shared RV32I types: instruction word, opcode enum, canonical NOP and the
// {pc, instr} packet carried through the IF/ID register.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  localparam rv32i_word NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    rv32i_word pc;
    rv32i_word instr;
  } fetch_pkt_t;

  function automatic rv32i_opcode get_opcode(input rv32i_word instr);
    return rv32i_opcode'(instr[6:0]);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// One {pc, instr} slot with a valid bit; flush empties it back to the NOP image.
// Serves both as the IF/ID register and as the fetch skid buffer.
module if_id_reg
  import rv32i_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       flush,
  input  fetch_pkt_t d,
  output logic       valid,
  output fetch_pkt_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= 1'b0;
      q.pc     <= '0;
      q.instr  <= NOP_INSTR;
    end else if (flush) begin
      valid    <= 1'b0;
      q.pc     <= '0;
      q.instr  <= NOP_INSTR;
    end else if (load) begin
      valid    <= 1'b1;
      q        <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, I-cache read handshake, IF/ID register with a
// one-entry skid buffer, and redirect handling that can drop an in-flight response.
module fetch_stage
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output rv32i_opcode if_opcode,
  output logic [2:0]  if_funct3,
  output logic [6:0]  if_funct7
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FULL, S_DROP} fetch_state_e;

  fetch_state_e state, state_n;
  rv32i_word    pc, pc_n, tgt, tgt_n;
  logic         ifid_load, ifid_flush, skid_load, skid_flush, skid_valid, consume;
  fetch_pkt_t   fetched, ifid_d, ifid_q, skid_q;

  assign consume    = if_valid && !stall;
  assign fetched    = '{pc: pc, instr: imem_rdata};
  // A parked skid entry always drains ahead of any new memory data.
  assign ifid_d     = skid_valid ? skid_q : fetched;
  assign ifid_flush = redirect || (consume && !ifid_load);

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    tgt_n      = tgt;
    ifid_load  = 1'b0;
    skid_load  = 1'b0;
    skid_flush = redirect;
    imem_read  = 1'b0;
    case (state)
      S_IDLE: begin
        state_n = S_REQ;
        if (redirect) pc_n = redirect_pc;
      end
      S_REQ: begin
        imem_read = 1'b1;
        if (redirect) begin
          if (imem_resp) pc_n = redirect_pc;
          else begin
            tgt_n   = redirect_pc;
            state_n = S_DROP;
          end
        end else if (imem_resp) begin
          pc_n = pc + 32'd4;
          if (!if_valid || !stall) ifid_load = 1'b1;
          else begin
            skid_load = 1'b1;
            state_n   = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = S_REQ;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          skid_flush = 1'b1;
          state_n    = S_REQ;
        end
      end
      S_DROP: begin
        // Address must stay stable until the stale response lands; a newer
        // redirect just replaces the pending target.
        imem_read = 1'b1;
        if (imem_resp) begin
          pc_n    = redirect ? redirect_pc : tgt;
          state_n = S_REQ;
        end else if (redirect) begin
          tgt_n = redirect_pc;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      tgt   <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      tgt   <= tgt_n;
    end
  end

  if_id_reg u_ifid (
    .clk   (clk),
    .rst   (rst),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_d),
    .valid (if_valid),
    .q     (ifid_q)
  );

  if_id_reg u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .flush (skid_flush),
    .d     (fetched),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign imem_address = pc;
  assign if_pc        = ifid_q.pc;
  assign if_instr     = ifid_q.instr;
  assign if_opcode    = get_opcode(ifid_q.instr);
  assign if_funct3    = ifid_q.instr[14:12];
  assign if_funct7    = ifid_q.instr[31:25];

endmodule
